// File: rtl/des_block_controller_if.sv
// Signal bundle between the CPU-side register block, the des_block array and the batch controller.
interface des_block_controller_if #(
    parameter int NUM_BLOCKS = 4,
    parameter int COUNT_W    = 48,
    parameter int SUM_W      = 64
);
    logic                          go;
    logic                          abort;
    logic [15:0]                   region_base;
    logic [15:0]                   num_batches;
    logic [NUM_BLOCKS-1:0]         block_done;
    logic [NUM_BLOCKS*COUNT_W-1:0] block_counter;
    logic                          block_restart;
    logic                          block_start;
    logic [NUM_BLOCKS*16-1:0]      block_region;
    logic [SUM_W-1:0]              total_count;
    logic [15:0]                   batches_done;
    logic                          busy;
    logic                          result_valid;

    // Environment side: CPU registers plus the des_block array.
    modport master (
        output go, abort, region_base, num_batches, block_done, block_counter,
        input  block_restart, block_start, block_region, total_count, batches_done, busy, result_valid
    );

    // Controller side.
    modport slave (
        input  go, abort, region_base, num_batches, block_done, block_counter,
        output block_restart, block_start, block_region, total_count, batches_done, busy, result_valid
    );
endinterface

// File: rtl/des_block_controller.sv
// Batch controller: restarts/starts NUM_BLOCKS des_blocks per batch, waits for all done flags,
// serially sums their counters and advances the region window until the requested batch count.
module des_block_controller #(
    parameter int NUM_BLOCKS = 4,
    parameter int COUNT_W    = 48,
    parameter int SUM_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    des_block_controller_if.slave bus
);
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTART = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_ACCUM   = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t                   state_r, state_nx_s;
    logic [15:0]              base_r, base_nx_s;
    logic [15:0]              batches_r, batches_nx_s;
    logic [15:0]              batches_done_r, batches_done_nx_s;
    logic [IDX_W-1:0]         acc_idx_r, acc_idx_nx_s;
    logic [SUM_W-1:0]         total_r, total_nx_s;
    logic [NUM_BLOCKS*16-1:0] region_r, region_nx_s;
    logic                     restart_r, restart_nx_s;
    logic                     start_r, start_nx_s;
    logic                     busy_r, busy_nx_s;
    logic                     valid_r, valid_nx_s;
    logic                     go_ok_s;
    logic                     last_blk_s;
    logic                     last_batch_s;
    logic [COUNT_W-1:0]       sel_count_s;

    assign go_ok_s      = bus.go && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_blk_s   = (acc_idx_r == IDX_W'(NUM_BLOCKS - 1));
    assign last_batch_s = ((batches_done_r + 16'd1) == batches_r);

    // AND-OR mux selecting the counter of the block currently being accumulated.
    always_comb begin
        sel_count_s = {COUNT_W{1'b0}};
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            sel_count_s = sel_count_s |
                (bus.block_counter[i*COUNT_W +: COUNT_W] & {COUNT_W{acc_idx_r == IDX_W'(i)}});
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort outranks go, go outranks the normal sequence.
    always_comb begin
        state_nx_s = state_r;
        if (bus.abort) begin
            state_nx_s = ST_IDLE;
        end else if (go_ok_s) begin
            state_nx_s = (bus.num_batches == 16'd0) ? ST_DONE : ST_RESTART;
        end else begin
            case (state_r)
                ST_IDLE:    state_nx_s = ST_IDLE;
                ST_RESTART: state_nx_s = ST_START;
                ST_START:   state_nx_s = ST_WAIT;
                ST_WAIT:    state_nx_s = (&bus.block_done) ? ST_ACCUM : ST_WAIT;
                ST_ACCUM:   state_nx_s = last_blk_s ? ST_NEXT : ST_ACCUM;
                ST_NEXT:    state_nx_s = last_batch_s ? ST_DONE : ST_RESTART;
                ST_DONE:    state_nx_s = ST_DONE;
                default:    state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values; regions follow the next base so they are valid on RESTART entry.
    always_comb begin
        base_nx_s         = base_r;
        batches_nx_s      = batches_r;
        batches_done_nx_s = batches_done_r;
        acc_idx_nx_s      = acc_idx_r;
        total_nx_s        = total_r;
        if (bus.abort) begin
            base_nx_s = base_r;
        end else if (go_ok_s) begin
            base_nx_s         = bus.region_base;
            batches_nx_s      = bus.num_batches;
            batches_done_nx_s = 16'd0;
            acc_idx_nx_s      = {IDX_W{1'b0}};
            total_nx_s        = {SUM_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            acc_idx_nx_s = {IDX_W{1'b0}};
        end else if (state_r == ST_ACCUM) begin
            acc_idx_nx_s = acc_idx_r + IDX_W'(1);
            total_nx_s   = total_r + SUM_W'(sel_count_s);
        end else if (state_r == ST_NEXT) begin
            batches_done_nx_s = batches_done_r + 16'd1;
            base_nx_s         = base_r + 16'(NUM_BLOCKS);
        end else begin
            acc_idx_nx_s = acc_idx_r;
        end

        region_nx_s = {(NUM_BLOCKS*16){1'b0}};
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            region_nx_s[i*16 +: 16] = base_nx_s + 16'(i);
        end

        restart_nx_s = (state_nx_s == ST_RESTART) || bus.abort;
        start_nx_s   = (state_nx_s == ST_START);
        busy_nx_s    = (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
        valid_nx_s   = (state_nx_s == ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_r         <= 16'd0;
            batches_r      <= 16'd0;
            batches_done_r <= 16'd0;
            acc_idx_r      <= {IDX_W{1'b0}};
            total_r        <= {SUM_W{1'b0}};
            region_r       <= {(NUM_BLOCKS*16){1'b0}};
            restart_r      <= 1'b0;
            start_r        <= 1'b0;
            busy_r         <= 1'b0;
            valid_r        <= 1'b0;
        end else begin
            base_r         <= base_nx_s;
            batches_r      <= batches_nx_s;
            batches_done_r <= batches_done_nx_s;
            acc_idx_r      <= acc_idx_nx_s;
            total_r        <= total_nx_s;
            region_r       <= region_nx_s;
            restart_r      <= restart_nx_s;
            start_r        <= start_nx_s;
            busy_r         <= busy_nx_s;
            valid_r        <= valid_nx_s;
        end
    end

    assign bus.block_restart = restart_r;
    assign bus.block_start   = start_r;
    assign bus.block_region  = region_r;
    assign bus.total_count   = total_r;
    assign bus.batches_done  = batches_done_r;
    assign bus.busy          = busy_r;
    assign bus.result_valid  = valid_r;
endmodule

// File: tb/tb_des_block_controller.sv
// Self-checking bench: behavioural des_block array, vector table, random runs and corner sequences.
module tb_des_block_controller;
    localparam int NB    = 4;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_block_controller_if #(.NUM_BLOCKS(NB), .COUNT_W(48), .SUM_W(64)) bus ();

    des_block_controller #(.NUM_BLOCKS(NB), .COUNT_W(48), .SUM_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0]       base;
        logic [15:0]       nb;
        logic [3:0][47:0]  cnt;
        logic [3:0][7:0]   dly;
        logic [63:0]       exp_total;
        logic [15:0]       exp_bd;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_done_cyc = 0;
    int          bidx     = 0;
    logic [47:0] cnt_cfg [0:7][0:3];
    int          dly_cfg [0:3];
    logic [3:0]  done_m;
    int          tmr [0:3];
    logic [47:0] cnt_m [0:3];
    bit          prev_all = 1'b0;
    bit          done_rise = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock; then the des_block model reacts to the controller outputs just sampled.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            done_m = 4'b0000;
            for (int i = 0; i < 4; i++) tmr[i] = 0;
        end else if (bus.block_restart) begin
            done_m = 4'b0000;
            for (int i = 0; i < 4; i++) tmr[i] = 0;
        end else if (bus.block_start) begin
            for (int i = 0; i < 4; i++) begin
                tmr[i]   = dly_cfg[i];
                cnt_m[i] = cnt_cfg[bidx][i];
            end
            bidx++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (tmr[i] > 0) begin
                    tmr[i]--;
                    if (tmr[i] == 0) done_m[i] = 1'b1;
                end
            end
        end
        bus.block_done    = done_m;
        bus.block_counter = {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]};
        done_rise = (&done_m) && !prev_all;
        prev_all  = &done_m;
        if (done_rise) last_done_cyc = cyc;
    endtask

    function automatic logic [63:0] exp_region(input logic [15:0] base, input int b);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = base + 16'(b*4 + i);
        return r;
    endfunction

    function automatic logic [63:0] prefix_sum(input int nbat);
        logic [63:0] s = 64'd0;
        for (int b = 0; b < nbat; b++)
            for (int i = 0; i < 4; i++) s += {16'd0, cnt_cfg[b][i]};
        return s;
    endfunction

    task automatic pulse_go(input logic [15:0] base, input logic [15:0] nb);
        bidx = 0;
        bus.region_base = base;
        bus.num_batches = nb;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        bus.region_base = 16'hDEAD;
        bus.num_batches = 16'hBEEF;
    endtask

    // Full run from go to result_valid, checking every batch boundary against the model.
    task automatic run(input string nm, input logic [15:0] base, input logic [15:0] nb,
                       input logic [63:0] exp_total, input logic [15:0] exp_bd, input bit spurious);
        int starts = 0, restarts = 0, steps = 0, start_step = 0;
        bit prev_restart = 1'b0, sent = 1'b0;
        pulse_go(base, nb);
        chk({nm, " total cleared on go"}, bus.total_count, 64'd0);
        forever begin
            if (bus.block_restart) restarts++;
            if (bus.block_start) begin
                chk({nm, " start follows restart"}, 64'(prev_restart), 64'd1);
                chk({nm, " region set"}, bus.block_region, exp_region(base, starts));
                chk({nm, " total at batch start"}, bus.total_count, prefix_sum(starts));
                starts++;
                start_step = steps;
            end
            if (done_rise && starts > 0)
                chk({nm, " no early accumulation"}, bus.total_count, prefix_sum(starts - 1));
            prev_restart = bus.block_restart;
            if (bus.result_valid || steps >= LIMIT) break;
            if (spurious && !sent && starts == 1 && (steps - start_step) == 2) begin
                sent = 1'b1;
                bus.go = 1'b1;
                bus.region_base = 16'h7777;
                bus.num_batches = 16'd9;
                step();
                steps++;
                bus.go = 1'b0;
                chk({nm, " go in WAIT keeps regions"}, bus.block_region, exp_region(base, 0));
                chk({nm, " go in WAIT keeps busy"}, 64'(bus.busy), 64'd1);
            end else begin
                step();
                steps++;
            end
        end
        chk({nm, " reached DONE"}, 64'(bus.result_valid), 64'd1);
        chk({nm, " total"}, bus.total_count, exp_total);
        chk({nm, " batches_done"}, 64'(bus.batches_done), 64'(exp_bd));
        chk({nm, " busy low"}, 64'(bus.busy), 64'd0);
        chk({nm, " restart pulses"}, 64'(restarts), 64'(nb));
        chk({nm, " start pulses"}, 64'(starts), 64'(nb));
        if (nb == 16'd0) chk({nm, " DONE in one cycle"}, 64'(steps), 64'd0);
        else chk({nm, " all-done to valid latency"}, 64'(cyc - last_done_cyc), 64'(NB + 2));
    endtask

    task automatic load_cfg(input vec_t v);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 4; i++) cnt_cfg[b][i] = v.cnt[i];
        for (int i = 0; i < 4; i++) dly_cfg[i] = int'(v.dly[i]);
    endtask

    vec_t vecs [5];

    initial begin
        logic [63:0] t;
        logic [63:0] exp_sum;
        logic [15:0] rb;
        logic [15:0] rn;
        int          k;
        vec_t        v;

        vecs[0] = '{16'h0010, 16'd1, {48'd13, 48'd11, 48'd7, 48'd5}, {8'd20, 8'd20, 8'd20, 8'd20}, 64'd36, 16'd1};
        vecs[1] = '{16'hFFFE, 16'd3, {48'd1, 48'd1, 48'd1, 48'd1}, {8'd2, 8'd2, 8'd2, 8'd2}, 64'd12, 16'd3};
        vecs[2] = '{16'h1234, 16'd1, {48'd4, 48'd3, 48'd2, 48'd1}, {8'd30, 8'd4, 8'd9, 8'd3}, 64'd10, 16'd1};
        vecs[3] = '{16'h0100, 16'd2, {4{48'hFFFF_FFFF_FFFF}}, {4{8'd5}}, 64'h0007_FFFF_FFFF_FFF8, 16'd2};
        vecs[4] = '{16'h4000, 16'd0, {48'd9, 48'd9, 48'd9, 48'd9}, {4{8'd3}}, 64'd0, 16'd0};

        bus.go = 1'b0;
        bus.abort = 1'b0;
        bus.region_base = 16'd0;
        bus.num_batches = 16'd0;
        bus.block_done = 4'b0000;
        bus.block_counter = '0;
        done_m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tmr[i] = 0;
            cnt_m[i] = 48'd0;
        end

        rst_n = 1'b0;
        step();
        step();
        chk("reset restart", 64'(bus.block_restart), 64'd0);
        chk("reset start", 64'(bus.block_start), 64'd0);
        chk("reset region", bus.block_region, 64'd0);
        chk("reset total", bus.total_count, 64'd0);
        chk("reset batches_done", 64'(bus.batches_done), 64'd0);
        chk("reset busy/valid", {62'd0, bus.busy, bus.result_valid}, 64'd0);
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 5; n++) begin
            v = vecs[n];
            load_cfg(v);
            run($sformatf("vec%0d", n), v.base, v.nb, v.exp_total, v.exp_bd, 1'b0);
            step();
        end

        // go while busy is ignored
        load_cfg(vecs[0]);
        for (int i = 0; i < 4; i++) dly_cfg[i] = 15;
        run("go_in_wait", 16'h0300, 16'd1, 64'd36, 16'd1, 1'b1);

        // abort during WAIT of batch 2 of 3
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 4; i++) cnt_cfg[b][i] = 48'(i + 1);
        for (int i = 0; i < 4; i++) dly_cfg[i] = 10;
        pulse_go(16'h0200, 16'd3);
        k = 0;
        for (int s = 0; s < LIMIT && k < 2; s++) begin
            step();
            if (bus.block_start) k++;
        end
        chk("abort reached batch 2", 64'(k), 64'd2);
        step();
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort restart pulse", 64'(bus.block_restart), 64'd1);
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort result_valid", 64'(bus.result_valid), 64'd0);
        chk("abort batches_done", 64'(bus.batches_done), 64'd1);
        chk("abort total kept", bus.total_count, 64'd10);
        step();
        chk("abort restart one cycle", 64'(bus.block_restart), 64'd0);
        chk("abort stays idle", 64'(bus.busy), 64'd0);
        run("after_abort", 16'h0800, 16'd1, 64'd10, 16'd1, 1'b0);

        // reset during ACCUM
        for (int i = 0; i < 4; i++) dly_cfg[i] = 4;
        pulse_go(16'h0500, 16'd1);
        k = 0;
        while (!done_rise && k < LIMIT) begin
            step();
            k++;
        end
        step();
        step();
        step();
        chk("accum partial total", 64'(bus.total_count != 64'd0), 64'd1);
        rst_n = 1'b0;
        step();
        chk("mid-run reset total", bus.total_count, 64'd0);
        chk("mid-run reset region", bus.block_region, 64'd0);
        chk("mid-run reset flags",
            {59'd0, bus.block_restart, bus.block_start, bus.busy, bus.result_valid, 1'b0}, 64'd0);
        rst_n = 1'b1;
        step();

        // randomized runs against the arithmetic model
        for (int r = 0; r < 6; r++) begin
            rb = 16'($urandom);
            rn = 16'($urandom_range(1, 3));
            exp_sum = 64'd0;
            for (int b = 0; b < 8; b++) begin
                for (int i = 0; i < 4; i++) begin
                    t = {$urandom, $urandom};
                    cnt_cfg[b][i] = t[47:0];
                    if (b < int'(rn)) exp_sum += {16'd0, t[47:0]};
                end
            end
            for (int i = 0; i < 4; i++) dly_cfg[i] = $urandom_range(1, 12);
            run($sformatf("rand%0d", r), rb, rn, exp_sum, rn, 1'b0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/des_block_controller.md
Name: des_block_controller

Overview:
Batch controller sitting directly upstream/downstream of an array of NUM_BLOCKS des_block instances.
- Assigns a distinct region_select to each block, restarts and starts them, then waits for all done flags.
- Serially sums their 48-bit counters into one total, then advances to the next batch of regions until the requested batch count is reached.
- Presents the final total to the CPU-side register interface.

Parameters:
NUM_BLOCKS, 4, number of des_block instances driven (1..16)
COUNT_W, 48, width of each block counter
SUM_W, 64, width of the accumulated total

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
go  in  1  one-cycle pulse: start a run (ignored unless in IDLE or DONE)
abort  in  1  one-cycle pulse: terminate run, return to IDLE
region_base  in  16  first region of the run, latched on go
num_batches  in  16  number of batches in the run, latched on go
block_done  in  NUM_BLOCKS  done outputs of the des_blocks
block_counter  in  NUM_BLOCKS*COUNT_W  counters; block i at [i*COUNT_W +: COUNT_W]
block_restart  out  1  restart_block to all blocks
block_start  out  1  start to all blocks
block_region  out  NUM_BLOCKS*16  region_select; block i at [i*16 +: 16]
total_count  out  SUM_W  accumulated sum of all counters of the run
batches_done  out  16  completed batches in the current run
busy  out  1  high in every state except IDLE and DONE
result_valid  out  1  high only in DONE

Behaviour:
- Reset values: state IDLE, block_restart=0, block_start=0, block_region=0, total_count=0, batches_done=0, busy=0, result_valid=0.
- Registers: base_reg (16b), batches_reg (16b), acc_idx (log2 NUM_BLOCKS, minimum 1 bit).
- block_region[i] = base_reg + i, mod 2^16. It is registered, stable from RESTART through ACCUM, and wraps 0xFFFF→0x0000.

State machine (all outputs registered or decoded from state only; no input-to-output combinational paths):
- IDLE: on go, latch region_base/num_batches, clear total_count and batches_done.
  - If num_batches==0, go to DONE.
  - Otherwise go to RESTART.
- RESTART: block_restart=1 for exactly 1 cycle → START.
- START: block_start=1 for exactly 1 cycle → WAIT.
- WAIT: stay while block_done is not all ones. When &block_done==1 → ACCUM with acc_idx=0.
- ACCUM: one block per cycle: total_count += zero-extended block_counter[acc_idx]. Addition is mod 2^SUM_W.
  - After the add for acc_idx==NUM_BLOCKS-1 → NEXT.
  - ACCUM lasts exactly NUM_BLOCKS cycles.
- NEXT: batches_done++, base_reg += NUM_BLOCKS (mod 2^16).
  - If batches_done+1==batches_reg → DONE.
  - Otherwise → RESTART.
- DONE: result_valid=1; total_count and batches_done held.
  - go starts a new run exactly as from IDLE; total_count is cleared in that cycle.
  - Nothing else leaves DONE except abort/reset.

Priority and boundary rules:
- Priority is rst_n > abort > go > normal transitions.
- abort in any state: next cycle state=IDLE, block_restart=1 for that one cycle, result_valid=0. total_count and batches_done keep their values for debug.
- go while busy: ignored; latched values are unchanged.
- Blocks are never restarted between WAIT entry and ACCUM exit, so counters are stable while being read.
- Minimum per-batch latency from entering RESTART to entering NEXT: 3 + NUM_BLOCKS cycles + WAIT duration.
- Reset mid-run: all outputs return to reset values on the next edge. block_restart is not pulsed; the blocks see rst_n themselves.

Test Plan:
- Single batch: NUM_BLOCKS=4, go with base=0x0010, num_batches=1.
  - Expected: regions 0x10..0x13; one restart pulse, then one start pulse the next cycle.
  - Model raises all done 20 cycles later with counters 5,7,11,13.
  - Required: total_count=36, batches_done=1, result_valid rises 4 cycles after ACCUM entry + 1.
- Multi-batch with wrap: base=0xFFFE, num_batches=3, every counter returns 1.
  - Required: region sets {FFFE,FFFF,0000,0001}, {0002..0005}, {0006..0009}; total=12; three restart/start pairs.
- Staggered done: done bits arrive at cycles 3,9,4,30.
  - Required: ACCUM is entered only after the last bit; no early accumulation.
- Max counters: all counters 0xFFFF_FFFF_FFFF, 2 batches.
  - Required: total = 8*(2^48-1), no truncation.
- abort during WAIT of batch 2 of 3.
  - Required: block_restart pulse the next cycle, IDLE, busy=0, result_valid=0, batches_done=1.
  - A following go restarts cleanly from the new region_base.
- num_batches=0: go → DONE in 1 cycle, total=0, no start/restart pulses.
- go during WAIT: ignored.
- rst_n low during ACCUM: all outputs return to reset values.
